// File: rtl/store_m.sv
// Tile-to-memory byte writer: drains buffered tiles MSB byte first
// into consecutive byte addresses until the requested length is stored.
module store_m #(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [23:0]           dram_addr,
    input  logic [19:0]           length,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  mem_we,
    output logic [23:0]           mem_addr,
    output logic [7:0]            mem_din,
    output logic                  valid_out
);

    localparam int NUM_BYTES = TILE_WIDTH / 8;
    localparam int BPV       = DATA_WIDTH / 8;
    localparam int CW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TILE = 2'd1;
    localparam logic [1:0] WRITING   = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);

    logic [1:0]            state_q, state_d;
    logic [23:0]           addr_q, addr_d;
    logic [23:0]           total_q, total_d;
    logic [23:0]           written_q, written_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic [TILE_WIDTH-1:0] shifted;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        total_d    = total_q;
        written_d  = written_q;
        byte_cnt_d = byte_cnt_q;
        tile_d     = tile_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    addr_d    = dram_addr;
                    total_d   = 24'(length) * 24'(BPV);
                    written_d = '0;
                    state_d   = (total_d == '0) ? DONE : WAIT_TILE;
                end
            end
            WAIT_TILE: begin
                if (tile_valid) begin
                    tile_d     = tile_in;
                    byte_cnt_d = '0;
                    state_d    = WRITING;
                end
            end
            WRITING: begin
                // Address wraps naturally in 24 bits
                addr_d    = addr_q + 24'd1;
                written_d = written_q + 24'd1;
                if (written_q + 24'd1 == total_q) begin
                    state_d = DONE;
                end else if (byte_cnt_q == LAST_BYTE) begin
                    state_d = WAIT_TILE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            total_q    <= '0;
            written_q  <= '0;
            byte_cnt_q <= '0;
            tile_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            written_q  <= written_d;
            byte_cnt_q <= byte_cnt_d;
            tile_q     <= tile_d;
        end
    end

    // Byte byte_cnt counted from the MSB end lands in the top byte
    always_comb begin
        shifted = tile_q << (int'(byte_cnt_q) * 8);
        mem_din = shifted[TILE_WIDTH-1 -: 8];
    end

    assign tile_ready = (state_q == WAIT_TILE);
    assign mem_we     = (state_q == WRITING);
    assign mem_addr   = addr_q;
    assign valid_out  = (state_q == DONE);

endmodule
